// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared encodings for the RV32 execute stage: ALU opcodes
//                (including MUL* and DIV*), branch funct3 codes, jump kinds,
//                the memory no-op code and the divider state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // ALU opcodes (5 bits, shared with ID decode)
  localparam logic [4:0] c_ALU_ADD    = 5'd0;
  localparam logic [4:0] c_ALU_SUB    = 5'd1;
  localparam logic [4:0] c_ALU_SLL    = 5'd2;
  localparam logic [4:0] c_ALU_SLT    = 5'd3;
  localparam logic [4:0] c_ALU_SLTU   = 5'd4;
  localparam logic [4:0] c_ALU_XOR    = 5'd5;
  localparam logic [4:0] c_ALU_SRL    = 5'd6;
  localparam logic [4:0] c_ALU_SRA    = 5'd7;
  localparam logic [4:0] c_ALU_OR     = 5'd8;
  localparam logic [4:0] c_ALU_AND    = 5'd9;
  localparam logic [4:0] c_ALU_LUI    = 5'd10;
  localparam logic [4:0] c_ALU_AUIPC  = 5'd11;
  localparam logic [4:0] c_ALU_MUL    = 5'd12;
  localparam logic [4:0] c_ALU_MULH   = 5'd13;
  localparam logic [4:0] c_ALU_MULHSU = 5'd14;
  localparam logic [4:0] c_ALU_MULHU  = 5'd15;
  localparam logic [4:0] c_ALU_DIV    = 5'd16;
  localparam logic [4:0] c_ALU_DIVU   = 5'd17;
  localparam logic [4:0] c_ALU_REM    = 5'd18;
  localparam logic [4:0] c_ALU_REMU   = 5'd19;

  // Branch funct3 codes
  localparam logic [2:0] c_BR_BEQ  = 3'b000;
  localparam logic [2:0] c_BR_BNE  = 3'b001;
  localparam logic [2:0] c_BR_BLT  = 3'b100;
  localparam logic [2:0] c_BR_BGE  = 3'b101;
  localparam logic [2:0] c_BR_BLTU = 3'b110;
  localparam logic [2:0] c_BR_BGEU = 3'b111;

  // Jump kinds
  localparam logic [1:0] c_JUMP_NONE = 2'd0;
  localparam logic [1:0] c_JUMP_JAL  = 2'd1;
  localparam logic [1:0] c_JUMP_JALR = 2'd2;

  // Memory op code carried by a bubble (all-zero so a bubble equals reset)
  localparam logic [3:0] c_MEM_NOP = 4'd0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= c_ALU_DIV) && (op <= c_ALU_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op >= c_ALU_MUL) && (op <= c_ALU_MULHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_divider.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_divider
//  Description : Iterative restoring divider for DIV/DIVU/REM/REMU. Signed
//                operations divide magnitudes and fix signs in DONE. Divide
//                by zero and signed overflow resolve at accept (IDLE->DONE).
//  Ports       : clk, rst (async, active-high)
//                i_start    - accept a new operation (only sampled in IDLE)
//                i_abort    - return to IDLE from any state
//                i_signed   - DIV/REM semantics
//                i_is_rem   - return remainder instead of quotient
//                i_dividend, i_divisor - operands (sampled at accept)
//                o_busy     - iterating
//                o_done     - result valid this cycle
//                o_result   - quotient or remainder, sign corrected
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_divider #(
  parameter int DIV_STEPS_PER_CYCLE = 1   // legal: 1, 2, 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_signed,
  input  logic        i_is_rem,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);
  import ex_stage_pkg::*;

  localparam int         ITERS       = 32 / DIV_STEPS_PER_CYCLE;
  localparam logic [5:0] c_LAST_ITER = 6'(ITERS - 1);

  div_state_e  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;

  logic [31:0] rem_step, quo_step, abs_a, abs_b;
  logic [32:0] trial;
  logic        div_zero, overflow;

  always_comb begin
    // Shift/subtract steps: quo_q holds the remaining dividend bits and
    // collects quotient bits from the right as they are resolved.
    rem_step = rem_q;
    quo_step = quo_q;
    trial    = '0;
    for (int i = 0; i < DIV_STEPS_PER_CYCLE; i++) begin
      trial = {rem_step, quo_step[31]} - {1'b0, dvsr_q};
      if (!trial[32]) begin
        rem_step = trial[31:0];
        quo_step = {quo_step[30:0], 1'b1};
      end else begin
        rem_step = {rem_step[30:0], quo_step[31]};
        quo_step = {quo_step[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    abs_a    = (i_signed && i_dividend[31]) ? (32'd0 - i_dividend) : i_dividend;
    abs_b    = (i_signed && i_divisor[31])  ? (32'd0 - i_divisor)  : i_divisor;
    div_zero = (i_divisor == 32'd0);
    overflow = i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);

    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (i_start) begin
          is_rem_d = i_is_rem;
          if (div_zero) begin
            quo_d     = 32'hFFFF_FFFF;
            rem_d     = i_dividend;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_DONE;
          end else if (overflow) begin
            quo_d     = 32'h8000_0000;
            rem_d     = 32'd0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_DONE;
          end else begin
            quo_d     = abs_a;
            rem_d     = 32'd0;
            dvsr_d    = abs_b;
            neg_quo_d = i_signed && (i_dividend[31] ^ i_divisor[31]);
            neg_rem_d = i_signed && i_dividend[31];
            count_d   = 6'd0;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d   = rem_step;
        quo_d   = quo_step;
        count_d = count_q + 6'd1;
        if (count_q == c_LAST_ITER) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (i_abort) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign o_busy   = (state_q == DIV_BUSY);
  assign o_done   = (state_q == DIV_DONE);
  assign o_result = is_rem_q ? (neg_rem_q ? (32'd0 - rem_q) : rem_q)
                             : (neg_quo_q ? (32'd0 - quo_q) : quo_q);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage RV32 pipeline. Single-cycle
//                ALU, branch/jump resolution, iterative divider that stalls
//                upstream, and the EX/MEM register feeding the MEM stage.
//                Optional single-cycle multiplier enabled by defining the
//                macro EX_MULDIV_MUL_EN; without it MUL* ops write 0 with
//                regwrite forced low.
//  Ports       : clk, rst (async, active-high)
//                EX_*_i     - ID/EX operands and control
//                flush_i    - kill the instruction in EX
//                EX_*_o     - registered EX/MEM fields
//                EX_stall_o - comb, hold PC, IF/ID and ID/EX
//                EX_redirect_o / EX_redirect_pc_o - comb taken branch/jump
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int DATA_WIDTH          = 32,  // only 32 supported
  parameter int DIV_STEPS_PER_CYCLE = 1    // legal: 1, 2, 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EX_valid_i,
  input  logic [4:0]            EX_alu_op_i,
  input  logic                  EX_alu_src_i,
  input  logic [DATA_WIDTH-1:0] EX_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] EX_imm_i,
  input  logic [DATA_WIDTH-1:0] EX_pc_i,
  input  logic                  EX_branch_i,
  input  logic [2:0]            EX_branch_op_i,
  input  logic [1:0]            EX_jump_i,
  input  logic [4:0]            EX_rd_add_i,
  input  logic                  EX_regwrite_i,
  input  logic                  EX_RD_mem_i,
  input  logic                  EX_WR_mem_i,
  input  logic [3:0]            EX_mem_op_i,
  input  logic [1:0]            EX_sel_to_reg_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] EX_alu_result_o,
  output logic [DATA_WIDTH-1:0] EX_rs2_data_o,
  output logic [DATA_WIDTH-1:0] EX_pc_o,
  output logic [DATA_WIDTH-1:0] EX_imm_o,
  output logic [4:0]            EX_rd_add_o,
  output logic                  EX_regwrite_o,
  output logic                  EX_RD_mem_o,
  output logic                  EX_WR_mem_o,
  output logic [3:0]            EX_mem_op_o,
  output logic [1:0]            EX_sel_to_reg_o,
  output logic                  EX_stall_o,
  output logic                  EX_redirect_o,
  output logic [DATA_WIDTH-1:0] EX_redirect_pc_o
);
  import ex_stage_pkg::*;

  logic [DATA_WIDTH-1:0] op_b, alu_res, mul_res, div_result;
  logic div_op, mul_op, mul_wr_ok, div_start, div_busy, div_done;
  logic stall, br_cmp, taken, issue;

  assign op_b   = EX_alu_src_i ? EX_imm_i : EX_rs2_data_i;
  assign div_op = is_div_op(EX_alu_op_i);
  assign mul_op = is_mul_op(EX_alu_op_i);

  always_comb begin
    alu_res = '0;
    case (EX_alu_op_i)
      c_ALU_ADD:   alu_res = EX_rs1_data_i + op_b;
      c_ALU_SUB:   alu_res = EX_rs1_data_i - op_b;
      c_ALU_SLL:   alu_res = EX_rs1_data_i << op_b[4:0];
      c_ALU_SRL:   alu_res = EX_rs1_data_i >> op_b[4:0];
      c_ALU_SRA:   alu_res = $signed(EX_rs1_data_i) >>> op_b[4:0];
      c_ALU_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(EX_rs1_data_i) < $signed(op_b))};
      c_ALU_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (EX_rs1_data_i < op_b)};
      c_ALU_XOR:   alu_res = EX_rs1_data_i ^ op_b;
      c_ALU_OR:    alu_res = EX_rs1_data_i | op_b;
      c_ALU_AND:   alu_res = EX_rs1_data_i & op_b;
      c_ALU_LUI:   alu_res = op_b;
      c_ALU_AUIPC: alu_res = EX_pc_i + op_b;
      default:     alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_MUL_EN
  // Sign-extending both operands to 64 bits lets one unsigned 64x64
  // product (truncated to 64 bits) serve all four MUL variants.
  logic [63:0] mul_a, mul_b, mul_prod;
  always_comb begin
    mul_a    = {{32{EX_rs1_data_i[31] & ((EX_alu_op_i == c_ALU_MULH) ||
                                         (EX_alu_op_i == c_ALU_MULHSU))}}, EX_rs1_data_i};
    mul_b    = {{32{op_b[31] & (EX_alu_op_i == c_ALU_MULH)}}, op_b};
    mul_prod = mul_a * mul_b;
    mul_res  = (EX_alu_op_i == c_ALU_MUL) ? mul_prod[31:0] : mul_prod[63:32];
  end
  assign mul_wr_ok = 1'b1;
`else
  assign mul_res   = '0;
  assign mul_wr_ok = !mul_op;
`endif

  // The divider accepts only from IDLE; while BUSY/DONE the held ID/EX
  // operands are ignored.
  assign div_start = EX_valid_i && div_op && !flush_i && !div_busy && !div_done;
  assign stall     = !rst && (div_start || (div_busy && !flush_i));
  assign EX_stall_o = stall;

  ex_stage_divider #(
    .DIV_STEPS_PER_CYCLE(DIV_STEPS_PER_CYCLE)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (div_start),
    .i_abort    (flush_i),
    .i_signed   ((EX_alu_op_i == c_ALU_DIV) || (EX_alu_op_i == c_ALU_REM)),
    .i_is_rem   ((EX_alu_op_i == c_ALU_REM) || (EX_alu_op_i == c_ALU_REMU)),
    .i_dividend (EX_rs1_data_i),
    .i_divisor  (op_b),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_result   (div_result)
  );

  always_comb begin
    br_cmp = 1'b0;
    case (EX_branch_op_i)
      c_BR_BEQ:  br_cmp = (EX_rs1_data_i == EX_rs2_data_i);
      c_BR_BNE:  br_cmp = (EX_rs1_data_i != EX_rs2_data_i);
      c_BR_BLT:  br_cmp = ($signed(EX_rs1_data_i) <  $signed(EX_rs2_data_i));
      c_BR_BGE:  br_cmp = ($signed(EX_rs1_data_i) >= $signed(EX_rs2_data_i));
      c_BR_BLTU: br_cmp = (EX_rs1_data_i <  EX_rs2_data_i);
      c_BR_BGEU: br_cmp = (EX_rs1_data_i >= EX_rs2_data_i);
      default:   br_cmp = 1'b0;
    endcase
  end

  assign issue         = !rst && EX_valid_i && !flush_i && !stall;
  assign taken         = (EX_branch_i && br_cmp) || (EX_jump_i == c_JUMP_JAL) || (EX_jump_i == c_JUMP_JALR);
  assign EX_redirect_o = issue && taken;
  assign EX_redirect_pc_o = (EX_jump_i == c_JUMP_JALR)
                          ? ((EX_rs1_data_i + EX_imm_i) & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1})
                          : (EX_pc_i + EX_imm_i);

  // EX/MEM register
  logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
  logic [4:0] rd_q, rd_d;
  logic       regwrite_q, regwrite_d, rd_mem_q, rd_mem_d, wr_mem_q, wr_mem_d;
  logic [3:0] mem_op_q, mem_op_d;
  logic [1:0] sel_q, sel_d;

  always_comb begin
    alu_result_d = '0;
    rs2_d        = '0;
    pc_d         = '0;
    imm_d        = '0;
    rd_d         = '0;
    regwrite_d   = 1'b0;
    rd_mem_d     = 1'b0;
    wr_mem_d     = 1'b0;
    mem_op_d     = c_MEM_NOP;
    sel_d        = '0;
    if (EX_valid_i && !flush_i && !stall) begin
      // A div op reaching here without stall is in the divider's DONE cycle.
      alu_result_d = div_op ? div_result : (mul_op ? mul_res : alu_res);
      rs2_d        = EX_rs2_data_i;
      pc_d         = EX_pc_i;
      imm_d        = EX_imm_i;
      rd_d         = EX_rd_add_i;
      regwrite_d   = EX_regwrite_i && mul_wr_ok;
      rd_mem_d     = EX_RD_mem_i;
      wr_mem_d     = EX_WR_mem_i;
      mem_op_d     = EX_mem_op_i;
      sel_d        = EX_sel_to_reg_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q <= '0;
      rs2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      rd_mem_q     <= 1'b0;
      wr_mem_q     <= 1'b0;
      mem_op_q     <= c_MEM_NOP;
      sel_q        <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      rs2_q        <= rs2_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rd_q         <= rd_d;
      regwrite_q   <= regwrite_d;
      rd_mem_q     <= rd_mem_d;
      wr_mem_q     <= wr_mem_d;
      mem_op_q     <= mem_op_d;
      sel_q        <= sel_d;
    end
  end

  assign EX_alu_result_o = alu_result_q;
  assign EX_rs2_data_o   = rs2_q;
  assign EX_pc_o         = pc_q;
  assign EX_imm_o        = imm_q;
  assign EX_rd_add_o     = rd_q;
  assign EX_regwrite_o   = regwrite_q;
  assign EX_RD_mem_o     = rd_mem_q;
  assign EX_WR_mem_o     = wr_mem_q;
  assign EX_mem_op_o     = mem_op_q;
  assign EX_sel_to_reg_o = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage: directed and randomized
//                ALU, branch, multiply and divide operations compared with a
//                behavioural reference model; flush and reset scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int STEPS      = 1;
  localparam int DIV_STALLS = 1 + 32 / STEPS;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid_i, EX_alu_src_i, EX_branch_i, EX_regwrite_i, EX_RD_mem_i, EX_WR_mem_i, flush_i;
  logic [4:0]  EX_alu_op_i, EX_rd_add_i;
  logic [31:0] EX_rs1_data_i, EX_rs2_data_i, EX_imm_i, EX_pc_i;
  logic [2:0]  EX_branch_op_i;
  logic [1:0]  EX_jump_i, EX_sel_to_reg_i;
  logic [3:0]  EX_mem_op_i;
  logic [31:0] EX_alu_result_o, EX_rs2_data_o, EX_pc_o, EX_imm_o, EX_redirect_pc_o;
  logic [4:0]  EX_rd_add_o;
  logic        EX_regwrite_o, EX_RD_mem_o, EX_WR_mem_o, EX_stall_o, EX_redirect_o;
  logic [3:0]  EX_mem_op_o;
  logic [1:0]  EX_sel_to_reg_o;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DATA_WIDTH(32), .DIV_STEPS_PER_CYCLE(STEPS)) dut (
    .clk(clk), .rst(rst),
    .EX_valid_i(EX_valid_i), .EX_alu_op_i(EX_alu_op_i), .EX_alu_src_i(EX_alu_src_i),
    .EX_rs1_data_i(EX_rs1_data_i), .EX_rs2_data_i(EX_rs2_data_i), .EX_imm_i(EX_imm_i),
    .EX_pc_i(EX_pc_i), .EX_branch_i(EX_branch_i), .EX_branch_op_i(EX_branch_op_i),
    .EX_jump_i(EX_jump_i), .EX_rd_add_i(EX_rd_add_i), .EX_regwrite_i(EX_regwrite_i),
    .EX_RD_mem_i(EX_RD_mem_i), .EX_WR_mem_i(EX_WR_mem_i), .EX_mem_op_i(EX_mem_op_i),
    .EX_sel_to_reg_i(EX_sel_to_reg_i), .flush_i(flush_i),
    .EX_alu_result_o(EX_alu_result_o), .EX_rs2_data_o(EX_rs2_data_o), .EX_pc_o(EX_pc_o),
    .EX_imm_o(EX_imm_o), .EX_rd_add_o(EX_rd_add_o), .EX_regwrite_o(EX_regwrite_o),
    .EX_RD_mem_o(EX_RD_mem_o), .EX_WR_mem_o(EX_WR_mem_o), .EX_mem_op_o(EX_mem_op_o),
    .EX_sel_to_reg_o(EX_sel_to_reg_o), .EX_stall_o(EX_stall_o),
    .EX_redirect_o(EX_redirect_o), .EX_redirect_pc_o(EX_redirect_pc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, b, pc);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    p  = '0;
    case (op)
      c_ALU_ADD:   return a + b;
      c_ALU_SUB:   return a - b;
      c_ALU_SLL:   return a << b[4:0];
      c_ALU_SRL:   return a >> b[4:0];
      c_ALU_SRA:   return sa >>> b[4:0];
      c_ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      c_ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      c_ALU_XOR:   return a ^ b;
      c_ALU_OR:    return a | b;
      c_ALU_AND:   return a & b;
      c_ALU_LUI:   return b;
      c_ALU_AUIPC: return pc + b;
      c_ALU_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      c_ALU_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      c_ALU_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      c_ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      c_ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      c_ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      c_ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      c_ALU_REMU: return (b == 0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] bop, input logic [31:0] a, b);
    case (bop)
      c_BR_BEQ:  return a == b;
      c_BR_BNE:  return a != b;
      c_BR_BLT:  return $signed(a) <  $signed(b);
      c_BR_BGE:  return $signed(a) >= $signed(b);
      c_BR_BLTU: return a <  b;
      c_BR_BGEU: return a >= b;
      default:   return 1'b0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic src, input logic [31:0] rs1, rs2, imm, pc,
                       input logic br, input logic [2:0] bop, input logic [1:0] jmp);
    EX_valid_i      = 1'b1;
    EX_alu_op_i     = op;
    EX_alu_src_i    = src;
    EX_rs1_data_i   = rs1;
    EX_rs2_data_i   = rs2;
    EX_imm_i        = imm;
    EX_pc_i         = pc;
    EX_branch_i     = br;
    EX_branch_op_i  = bop;
    EX_jump_i       = jmp;
    EX_rd_add_i     = 5'($urandom_range(1, 31));
    EX_regwrite_i   = 1'b1;
    EX_RD_mem_i     = 1'($urandom);
    EX_WR_mem_i     = 1'($urandom);
    EX_mem_op_i     = 4'($urandom_range(1, 15));
    EX_sel_to_reg_i = 2'($urandom);
  endtask

  task automatic idle();
    EX_valid_i = 1'b0;
  endtask

  // One ALU/MUL instruction: no stall, result and control one edge later.
  task automatic alu_case(input string tag, input logic [4:0] op, input logic src,
                          input logic [31:0] rs1, rs2, imm, pc);
    logic [31:0] exp;
    logic [13:0] exp_ctrl;
    logic        wr;
    drive(op, src, rs1, rs2, imm, pc, 1'b0, 3'd0, 2'd0);
    exp = ref_alu(op, rs1, src ? imm : rs2, pc);
    wr  = 1'b1;
`ifndef EX_MULDIV_MUL_EN
    if (op >= c_ALU_MUL && op <= c_ALU_MULHU) begin
      exp = 32'd0;
      wr  = 1'b0;
    end
`endif
    exp_ctrl = {EX_rd_add_i, wr, EX_RD_mem_i, EX_WR_mem_i, EX_mem_op_i, EX_sel_to_reg_i};
    #2;
    check({tag, "_stall"}, 32'(EX_stall_o), 32'd0);
    step();
    check(tag, EX_alu_result_o, exp);
    check({tag, "_ctrl"}, 32'({EX_rd_add_o, EX_regwrite_o, EX_RD_mem_o, EX_WR_mem_o,
                               EX_mem_op_o, EX_sel_to_reg_o}), 32'(exp_ctrl));
    check({tag, "_pc"}, EX_pc_o, pc);
    idle();
  endtask

  task automatic br_case(input string tag, input logic [2:0] bop, input logic [1:0] jmp,
                         input logic [31:0] rs1, rs2, imm, pc);
    logic        tk;
    logic [31:0] tgt;
    drive(c_ALU_ADD, 1'b0, rs1, rs2, imm, pc, (jmp == 2'd0), bop, jmp);
    tk  = (jmp != 2'd0) ? 1'b1 : ref_taken(bop, rs1, rs2);
    tgt = (jmp == 2'd2) ? ((rs1 + imm) & ~32'd1) : (pc + imm);
    #2;
    check({tag, "_redir"}, 32'(EX_redirect_o), 32'(tk));
    if (tk) check({tag, "_tgt"}, EX_redirect_pc_o, tgt);
    step();
    idle();
  endtask

  // Divide: count stall cycles (bounded), confirm bubbles while stalled,
  // then the result lands on the edge ending the first unstalled cycle.
  task automatic div_case(input string tag, input logic [4:0] op, input logic [31:0] a, b);
    int          stalls = 0;
    int          bad    = 0;
    int          exp_st;
    logic [31:0] exp;
    exp    = ref_alu(op, a, b, 32'd0);
    exp_st = (b == 0 || ((op == c_ALU_DIV || op == c_ALU_REM) &&
                         a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : DIV_STALLS;
    drive(op, 1'b0, a, b, 32'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 200; i++) begin
      #2;
      if (!EX_stall_o) break;
      stalls++;
      step();
      if (EX_regwrite_o !== 1'b0 || EX_alu_result_o !== 32'd0 || EX_mem_op_o !== c_MEM_NOP) bad++;
    end
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_st));
    check({tag, "_bubbles"}, 32'(bad), 32'd0);
    step();
    check(tag, EX_alu_result_o, exp);
    check({tag, "_wr"}, 32'(EX_regwrite_o), 32'd1);
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [2:0]  bops [6];
    bops = '{c_BR_BEQ, c_BR_BNE, c_BR_BLT, c_BR_BGE, c_BR_BLTU, c_BR_BGEU};

    rst = 1'b1;
    EX_valid_i = 0; EX_alu_op_i = 0; EX_alu_src_i = 0; EX_rs1_data_i = 0; EX_rs2_data_i = 0;
    EX_imm_i = 0; EX_pc_i = 0; EX_branch_i = 0; EX_branch_op_i = 0; EX_jump_i = 0;
    EX_rd_add_i = 0; EX_regwrite_i = 0; EX_RD_mem_i = 0; EX_WR_mem_i = 0; EX_mem_op_i = 0;
    EX_sel_to_reg_i = 0; flush_i = 0;
    step();
    step();
    check("rst_result", EX_alu_result_o, 32'd0);
    check("rst_ctrl", 32'({EX_rd_add_o, EX_regwrite_o, EX_RD_mem_o, EX_WR_mem_o,
                           EX_mem_op_o, EX_sel_to_reg_o}), 32'd0);
    check("rst_stall_redir", 32'({EX_stall_o, EX_redirect_o}), 32'd0);
    check("rst_pc", EX_pc_o, 32'd0);
    rst = 1'b0;
    step();

    // Directed ALU points
    alu_case("add_wrap", c_ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h40);
    alu_case("sra_neg",  c_ALU_SRA, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h44);
    alu_case("sub_wrap", c_ALU_SUB, 1'b0, 32'd0, 32'd1, 32'd0, 32'h48);
    alu_case("lui",      c_ALU_LUI, 1'b1, 32'h1234_5678, 32'd0, 32'hABCD_E000, 32'h4C);
    alu_case("auipc",    c_ALU_AUIPC, 1'b1, 32'd0, 32'd0, 32'h0000_1000, 32'h50);

    // Invalid instruction -> bubble
    EX_valid_i = 1'b0;
    EX_rs1_data_i = 32'hDEAD_BEEF;
    step();
    check("invalid_bubble_wr", 32'(EX_regwrite_o), 32'd0);
    check("invalid_bubble_res", EX_alu_result_o, 32'd0);

    // Random ALU
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 11));
      alu_case($sformatf("rand_alu%0d", i), op, 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    end

    // Branches and jumps
    br_case("blt",  c_BR_BLT,  2'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
    br_case("bltu", c_BR_BLTU, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
    br_case("jal",  3'd0, 2'd1, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h200);
    br_case("jalr", 3'd0, 2'd2, 32'h0000_1001, 32'd0, 32'h10, 32'h300);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      br_case($sformatf("rand_br%0d", i), bops[$urandom_range(0, 5)], 2'd0, a, b, $urandom, $urandom);
    end
    drive(c_ALU_ADD, 1'b0, 0, 0, 32'h40, 32'h10, 1'b0, 3'd0, 2'd1);
    flush_i = 1'b1;
    #2;
    check("jal_flushed_redir", 32'(EX_redirect_o), 32'd0);
    step();
    check("jal_flushed_bubble", 32'(EX_regwrite_o), 32'd0);
    flush_i = 1'b0;
    idle();

    // Multiplier (expectation depends on build)
    alu_case("mulhu_max", c_ALU_MULHU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h60);
    for (int i = 0; i < 8; i++) begin
      op = 5'($urandom_range(12, 15));
      alu_case($sformatf("rand_mul%0d", i), op, 1'b0, $urandom, $urandom, 32'd0, 32'h64);
    end

    // Divider
    div_case("div_m7_2",   c_ALU_DIV,  32'hFFFF_FFF9, 32'd2);
    div_case("rem_m7_2",   c_ALU_REM,  32'hFFFF_FFF9, 32'd2);
    div_case("divu_5_0",   c_ALU_DIVU, 32'd5, 32'd0);
    div_case("rem_x_0",    c_ALU_REM,  32'hFFFF_FF00, 32'd0);
    div_case("div_ovf",    c_ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    div_case("rem_ovf",    c_ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    div_case("remu_big",   c_ALU_REMU, 32'hFFFF_FFFF, 32'h0001_0003);
    for (int i = 0; i < 6; i++) begin
      op = 5'($urandom_range(16, 19));
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      div_case($sformatf("rand_div%0d", i), op, $urandom, b);
    end

    // Flush during BUSY cycle 10
    drive(c_ALU_DIV, 1'b0, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    #2;
    check("flush_accept_stall", 32'(EX_stall_o), 32'd1);
    step();
    repeat (9) step();
    flush_i = 1'b1;
    #1;
    check("flush_stall_drop", 32'(EX_stall_o), 32'd0);
    step();
    check("flush_bubble", 32'({EX_regwrite_o, EX_alu_result_o != 32'd0}), 32'd0);
    flush_i = 1'b0;
    alu_case("after_flush_add", c_ALU_ADD, 1'b0, 32'd3, 32'd4, 32'd0, 32'h80);

    // Asynchronous reset clears a loaded EX/MEM
    alu_case("pre_rst_add", c_ALU_ADD, 1'b0, 32'd5, 32'd6, 32'd0, 32'h90);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result", EX_alu_result_o, 32'd0);
    check("async_rst_pc", EX_pc_o, 32'd0);
    #1;
    rst = 1'b0;
    step();

    // Reset mid-divide
    drive(c_ALU_DIVU, 1'b0, 32'd99, 32'd3, 32'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    repeat (5) step();
    #2;
    check("busy_stall", 32'(EX_stall_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_div_stall", 32'(EX_stall_o), 32'd0);
    #1;
    rst = 1'b0;
    idle();
    step();
    alu_case("after_rst_add", c_ALU_XOR, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'hA0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
